cod_7seg_linha: RTL and testbench
=================================

// Module: cod_7seg_linha
// PURPOSE
//   Reverse of the row-to-7-segment decoder. Samples a 7-segment pattern (a..g), filters
//   it for stability and encodes it back to its 3-bit row code {A,B,C}.
//   The code is delivered on a valid/ack handshake. Used to read back display buses in self-test.
// PARAMETERS
//   STABLE_CYC  4  consecutive identical samples required before a pattern is accepted (>=1)
//   CNT_W       3  width of stability counter; must hold STABLE_CYC
//   ERRCNT_W    8  width of invalid-pattern counter (ERR_CNT_EN only)
// PORTS
//   clk       in   1         system clock, rising edge
//   reset     in   1         asynchronous, active-high
//   seg_in    in   7         pattern; [6]=a [5]=b [4]=c [3]=d [2]=e [1]=f [0]=g, 1=segment lit
//   ack       in   1         consumer accepts line_out; only meaningful while valid=1
//   line_out  out  3         encoded row {A,B,C}, A=MSB
//   valid     out  1         line_out holds a new, accepted code
//   err       out  1         1-cycle pulse: stable pattern not in code table
//   err_cnt   out  ERRCNT_W  saturating count of err pulses
// BEHAVIOUR
//   Code table, abcdefg -> ABC (all other non-blank patterns are invalid):
//     1001111->000  0010010->001  0000110->010  1001100->011
//     0100100->100  0100000->101  0001111->110  1111111->111
//   Input stage: seg_in registered into seg_q every cycle. All decisions use seg_q.
//   Internal regs: cand (7b), cnt (CNT_W), last (7b, last reported/rejected pattern).
//   FSM:
//     IDLE    : if seg_q==0000000 -> last<=0000000 (blank re-arms repeat reporting);
//               else if seg_q!=last -> cand<=seg_q, cnt<=1, SETTLE.
//     SETTLE  : seg_q==cand -> cnt<=cnt+1; seg_q!=cand -> cand<=seg_q, cnt<=1.
//               seg_q==0000000 -> IDLE, last<=0000000.
//               When cnt==STABLE_CYC: valid code -> line_out<=code, valid<=1, WAIT_ACK;
//               invalid code -> err<=1 for 1 cycle, last<=cand, IDLE.
//     WAIT_ACK: valid=1, line_out frozen, seg_in ignored.
//               ack=1 -> valid<=0, last<=cand, IDLE.
//   Latency: a pattern first present on seg_in before edge t and held stable.
//     valid (or err) rises at edge t+STABLE_CYC+1.
//   Handshake: ack while valid=0 is ignored.
//     valid falls on the edge that samples ack=1; it does not rise again for >=1 cycle.
//   Same pattern held after ack or err is not re-reported.
//     It must pass through blank or another pattern first.
//   Glitch shorter than STABLE_CYC samples restarts the count; never reported.
//   Reset (any time, incl. mid-SETTLE/WAIT_ACK): state=IDLE; seg_q=cand=last=0.
//     cnt=0; line_out=000; valid=0; err=0; err_cnt=0. Takes effect immediately.
//   err and valid are never high in the same cycle.
// CONFIGURATION
//   ERR_CNT_EN defined: err_cnt increments on each err pulse.
//     It saturates at 2^ERRCNT_W-1 and clears only on reset.
//   ERR_CNT_EN undefined: err_cnt tied to 0 and no counter logic is built.
//     err pulse unchanged.
// TESTING
//   1 reset: assert reset mid-WAIT_ACK -> valid=0, line_out=000, err=0, err_cnt=0 same cycle.
//   2 encode all 8: drive each table pattern, STABLE_CYC=4, ack 2 cycles after valid.
//     -> line_out 000..111 in order. valid rises 5 edges after seg_in change.
//   3 glitch: 1001100 for 3 cycles, then 0100100 held.
//     -> no report of 011. valid with line_out=100 5 edges after the switch.
//   4 invalid: 1110000 held 10 cycles -> exactly one err pulse, valid stays 0.
//     With ERR_CNT_EN, err_cnt=1. Repeat 300 invalid/blank pairs -> err_cnt=255.
//   5 repeat/handshake: 0000110 held, ack=0 for 20 cycles -> valid and 010 held, input changes ignored.
//     Then ack=1 -> valid falls next edge, no re-report while 0000110 held.
//     Blank 1 cycle then 0000110 again -> new valid with 010.

Source files
------------

// File: rtl/cod_7seg_linha.sv
// cod_7seg_linha: reads a 7-segment pattern (a..g) back into its 3-bit row code.
// The input is registered, held for STABLE_CYC identical samples, then looked up.
// A table hit is offered on a valid/ack handshake. A miss gives a one-cycle err pulse.
// A pattern that has been reported or rejected is not reported again until the
// input goes blank or moves to a different pattern.
// Optional feature macro: ERR_CNT_EN (saturating counter of err pulses on err_cnt).
module cod_7seg_linha #(
  parameter int STABLE_CYC = 4,
  parameter int CNT_W      = 3,
  parameter int ERRCNT_W   = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [6:0]          seg_in,
  input  logic                ack,
  output logic [2:0]          line_out,
  output logic                valid,
  output logic                err,
  output logic [ERRCNT_W-1:0] err_cnt
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SETTLE   = 2'd1,
    WAIT_ACK = 2'd2
  } state_t;

  localparam logic [6:0]       BLANK   = 7'b0000000;
  localparam logic [CNT_W-1:0] CNT_END = CNT_W'(STABLE_CYC);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic [6:0]       seg_q;
  logic [6:0]       cand_q, cand_d;
  logic [6:0]       last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       line_q, line_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;

  logic [3:0]       enc;
  logic             enc_ok;
  logic [2:0]       enc_code;
  logic             seg_blank;
  logic             stable;

  // Pattern lookup: returns {hit, code}; any pattern not in the table is a miss.
  function automatic logic [3:0] encode(input logic [6:0] s);
    case (s)
      7'b1001111: encode = {1'b1, 3'd0};
      7'b0010010: encode = {1'b1, 3'd1};
      7'b0000110: encode = {1'b1, 3'd2};
      7'b1001100: encode = {1'b1, 3'd3};
      7'b0100100: encode = {1'b1, 3'd4};
      7'b0100000: encode = {1'b1, 3'd5};
      7'b0001111: encode = {1'b1, 3'd6};
      7'b1111111: encode = {1'b1, 3'd7};
      default:    encode = 4'b0000;
    endcase
  endfunction

  assign enc       = encode(cand_q);
  assign enc_ok    = enc[3];
  assign enc_code  = enc[2:0];
  assign seg_blank = (seg_q == BLANK);
  assign stable    = (cnt_q == CNT_END);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; a completed stability count wins over a late input change.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (!seg_blank && (seg_q != last_q)) state_d = SETTLE;
      end
      SETTLE: begin
        if (stable)         state_d = enc_ok ? WAIT_ACK : IDLE;
        else if (seg_blank) state_d = IDLE;
      end
      WAIT_ACK: begin
        if (ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath/output next values: candidate tracking, repeat suppression, handshake.
  always_comb begin
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    line_d  = line_q;
    valid_d = valid_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (seg_blank) begin
          last_d = BLANK;
        end else if (seg_q != last_q) begin
          cand_d = seg_q;
          cnt_d  = CNT_ONE;
        end
      end
      SETTLE: begin
        if (stable) begin
          if (enc_ok) begin
            line_d  = enc_code;
            valid_d = 1'b1;
          end else begin
            err_d  = 1'b1;
            last_d = cand_q;
          end
        end else if (seg_blank) begin
          last_d = BLANK;
          cnt_d  = '0;
        end else if (seg_q == cand_q) begin
          cnt_d = cnt_q + CNT_ONE;
        end else begin
          cand_d = seg_q;
          cnt_d  = CNT_ONE;
        end
      end
      WAIT_ACK: begin
        if (ack) begin
          valid_d = 1'b0;
          last_d  = cand_q;
        end
      end
      default: begin
        valid_d = 1'b0;
      end
    endcase
  end

  // Input sampling and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg_q   <= BLANK;
      cand_q  <= BLANK;
      last_q  <= BLANK;
      cnt_q   <= '0;
      line_q  <= 3'b000;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      seg_q   <= seg_in;
      cand_q  <= cand_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      line_q  <= line_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign line_out = line_q;
  assign valid    = valid_q;
  assign err      = err_q;

`ifdef ERR_CNT_EN
  logic [ERRCNT_W-1:0] err_cnt_q;

  // Saturating count of rejected patterns, cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                         err_cnt_q <= '0;
    else if (err_d && (err_cnt_q != '1)) err_cnt_q <= err_cnt_q + 1'b1;
  end

  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_cod_7seg_linha.sv
// Bench for cod_7seg_linha: directed steps with a queue of expected row codes.
module tb_cod_7seg_linha;

  localparam int STABLE_CYC = 4;
  localparam int LAT        = STABLE_CYC + 2;  // ticks from driving seg_in to valid/err visible

  logic       clk;
  logic       reset;
  logic [6:0] seg_in;
  logic       ack;
  logic [2:0] line_out;
  logic       valid;
  logic       err;
  logic [7:0] err_cnt;

  int errors = 0;
  int checks = 0;
  logic [2:0] sb[$];

  logic [6:0] tbl [8] = '{7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                          7'b0100100, 7'b0100000, 7'b0001111, 7'b1111111};

  cod_7seg_linha #(.STABLE_CYC(STABLE_CYC), .CNT_W(3), .ERRCNT_W(8)) dut (
    .clk(clk), .reset(reset), .seg_in(seg_in), .ack(ack),
    .line_out(line_out), .valid(valid), .err(err), .err_cnt(err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for valid; counts ticks and any err pulse seen meanwhile.
  task automatic wait_valid(output int n, output int errs);
    n = 0;
    errs = 0;
    while (valid !== 1'b1 && n < 40) begin
      tick();
      n++;
      if (err === 1'b1) errs++;
    end
  endtask

  // Pop the expected code and compare it against line_out.
  task automatic sb_check(input string tag);
    logic [2:0] e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk(tag, {29'd0, line_out}, {29'd0, e});
    end
  endtask

  task automatic do_ack(input string tag);
    tick();
    tick();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk(tag, {31'd0, valid}, 32'd0);
  endtask

  initial begin
    int n, e, errp, vhi;
    logic [7:0] exp_cnt;
    logic held_ok;

    reset  = 1'b1;
    seg_in = 7'b0;
    ack    = 1'b0;
    tick();
    tick();
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_line", {29'd0, line_out}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_errcnt", {24'd0, err_cnt}, 32'd0);
    reset = 1'b0;
    tick();
    tick();

    // Encode all eight table entries in order, acking two cycles after valid.
    for (int i = 0; i < 8; i++) begin
      seg_in = tbl[i];
      sb.push_back(3'(i));
      wait_valid(n, e);
      chk($sformatf("enc%0d_lat", i), n, LAT);
      chk($sformatf("enc%0d_noerr", i), e, 0);
      sb_check($sformatf("enc%0d_line", i));
      do_ack($sformatf("enc%0d_ackfall", i));
    end

    // Short glitch of 1001100 followed by 0100100 held: only 100 is reported.
    seg_in = 7'b1001100;
    tick();
    tick();
    tick();
    chk("glitch_novalid", {31'd0, valid}, 32'd0);
    seg_in = 7'b0100100;
    sb.push_back(3'd4);
    wait_valid(n, e);
    chk("glitch_lat", n, LAT);
    sb_check("glitch_line");
    do_ack("glitch_ackfall");

    // Invalid pattern held for 10 cycles: exactly one err pulse, no valid.
    seg_in = 7'b1110000;
    errp = 0;
    vhi = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (err === 1'b1) errp++;
      if (valid === 1'b1) vhi++;
    end
    chk("inv_errpulses", errp, 1);
    chk("inv_novalid", vhi, 0);
`ifdef ERR_CNT_EN
    exp_cnt = 8'd1;
`else
    exp_cnt = 8'd0;
`endif
    chk("inv_errcnt1", {24'd0, err_cnt}, {24'd0, exp_cnt});

    // 300 more blank/invalid pairs: counter saturates.
    errp = 0;
    for (int k = 0; k < 300; k++) begin
      seg_in = 7'b0;
      tick();
      tick();
      tick();
      seg_in = 7'b1110000;
      for (int i = 0; i < 8; i++) begin
        tick();
        if (err === 1'b1) errp++;
        if (valid === 1'b1) vhi++;
      end
    end
    chk("pairs_errpulses", errp, 300);
    chk("pairs_novalid", vhi, 0);
`ifdef ERR_CNT_EN
    exp_cnt = 8'd255;
`else
    exp_cnt = 8'd0;
`endif
    chk("pairs_errcnt_sat", {24'd0, err_cnt}, {24'd0, exp_cnt});

    // Handshake hold, repeat suppression, and re-arm through blank.
    seg_in = 7'b0;
    tick();
    tick();
    tick();
    seg_in = 7'b0000110;
    sb.push_back(3'd2);
    wait_valid(n, e);
    chk("hold_lat", n, LAT);
    sb_check("hold_line");
    held_ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (i < 15) seg_in = (i % 3 == 0) ? 7'b0 : tbl[i % 8];
      else        seg_in = 7'b0000110;
      tick();
      if (valid !== 1'b1 || line_out !== 3'd2 || err !== 1'b0) held_ok = 1'b0;
    end
    chk("hold_frozen", {31'd0, held_ok}, 32'd1);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("hold_ackfall", {31'd0, valid}, 32'd0);
    vhi = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (valid === 1'b1) vhi++;
    end
    chk("norepeat", vhi, 0);
    seg_in = 7'b0;
    tick();
    seg_in = 7'b0000110;
    sb.push_back(3'd2);
    wait_valid(n, e);
    chk("rearm_lat", n, LAT);
    sb_check("rearm_line");

    // Ack while valid is low must be ignored; then reset during WAIT_ACK.
    do_ack("rearm_ackfall");
    seg_in = 7'b1001111;
    ack = 1'b1;
    tick();
    tick();
    ack = 1'b0;
    sb.push_back(3'd0);
    wait_valid(n, e);
    chk("earlyack_lat", n, LAT - 2);
    sb_check("earlyack_line");
    tick();
    reset = 1'b1;
    #1;
    chk("midrst_valid", {31'd0, valid}, 32'd0);
    chk("midrst_line", {29'd0, line_out}, 32'd0);
    chk("midrst_err", {31'd0, err}, 32'd0);
    chk("midrst_errcnt", {24'd0, err_cnt}, 32'd0);
    seg_in = 7'b0;
    tick();
    reset = 1'b0;
    tick();
    chk("sb_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
